multi_pulse_widen: RTL and testbench

Multi-channel, single-clock pulse widener: each single-cycle event on a channel becomes an output pulse of programmable length, followed by an enforced low gap. Events arriving during a pulse are queued per channel, not merged, so no event is lost while the queue has room. It sits in the fast domain in front of toggle or edge-detect synchronisers. It guarantees that every event reaches a slow domain as a distinct, wide-enough pulse, and it removes the minimum input-spacing restriction of the bare single-bit fast-to-slow path.

---
 rtl/multi_pulse_widen_if.sv | 26 ++
 rtl/multi_pulse_widen.sv | 137 +++++++++++++
 tb/tb_multi_pulse_widen.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/multi_pulse_widen_if.sv
// Bus bundle for the multi-channel pulse widener: event inputs, stretch
// length, overflow clear, and the per-channel status outputs.
interface multi_pulse_widen_if #(
  parameter int CH = 4,
  parameter int WW = 4
) ();
  logic [CH-1:0] din;
  logic [WW-1:0] width;
  logic          ovf_clr;
  logic [CH-1:0] dout;
  logic [CH-1:0] busy;
  logic [CH-1:0] pend_full;
  logic [CH-1:0] ovf;

  // Event source / status consumer side
  modport master (
    output din, width, ovf_clr,
    input  dout, busy, pend_full, ovf
  );

  // Widener side
  modport slave (
    input  din, width, ovf_clr,
    output dout, busy, pend_full, ovf
  );
endinterface

// File: rtl/multi_pulse_widen.sv
// Multi-channel pulse widener. Each single-cycle event becomes a pulse of
// max(width,1) cycles followed by MIN_GAP low cycles; events that arrive
// while a channel is busy are counted and replayed, never merged.
module multi_pulse_widen #(
  parameter int CH      = 4,
  parameter int WW      = 4,
  parameter int MIN_GAP = 2,
  parameter int QW      = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multi_pulse_widen_if.slave   bus
);

  localparam int GW = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP - 1);
  localparam logic [QW-1:0] PEND_MAX = {QW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e          st_q   [CH];
  state_e          st_d   [CH];
  logic [WW-1:0]   len_q  [CH];
  logic [WW-1:0]   len_d  [CH];
  logic [GW-1:0]   gap_q  [CH];
  logic [GW-1:0]   gap_d  [CH];
  logic [QW-1:0]   pend_q [CH];
  logic [QW-1:0]   pend_d [CH];
  logic [CH-1:0]   dout_q, dout_d;
  logic [CH-1:0]   busy_q, busy_d;
  logic [CH-1:0]   full_q, full_d;
  logic [CH-1:0]   ovf_q, ovf_d;
  logic [WW-1:0]   len_load;

  // Zero width is stretched to a single cycle; len counts remaining cycles after this one
  assign len_load = (bus.width == '0) ? '0 : bus.width - WW'(1);

  // Per-channel next state: pulse sequencing, event queueing and overflow
  always_comb begin
    dout_d = '0;
    busy_d = '0;
    full_d = '0;
    ovf_d  = '0;
    for (int i = 0; i < CH; i++) begin
      logic queue_ev;
      logic drop;
      st_d[i]   = st_q[i];
      len_d[i]  = len_q[i];
      gap_d[i]  = gap_q[i];
      pend_d[i] = pend_q[i];
      queue_ev  = 1'b0;
      drop      = 1'b0;
      case (st_q[i])
        S_IDLE: begin
          if (bus.din[i]) begin
            st_d[i]  = S_HIGH;
            len_d[i] = len_load;
          end
        end
        S_HIGH: begin
          queue_ev = bus.din[i];
          if (len_q[i] == '0) begin
            st_d[i]  = S_GAP;
            gap_d[i] = GAP_LOAD;
          end else begin
            len_d[i] = len_q[i] - WW'(1);
          end
        end
        S_GAP: begin
          if (gap_q[i] != '0) begin
            gap_d[i] = gap_q[i] - GW'(1);
            queue_ev = bus.din[i];
          end else if (pend_q[i] != '0) begin
            // Replaying a queued event; a simultaneous new event takes its
            // slot, so pend only drops when nothing new arrives.
            st_d[i]  = S_HIGH;
            len_d[i] = len_load;
            if (!bus.din[i]) pend_d[i] = pend_q[i] - QW'(1);
          end else if (bus.din[i]) begin
            st_d[i]  = S_HIGH;
            len_d[i] = len_load;
          end else begin
            st_d[i] = S_IDLE;
          end
        end
        default: begin
          st_d[i] = S_IDLE;
        end
      endcase
      if (queue_ev) begin
        if (pend_q[i] == PEND_MAX) drop = 1'b1;
        else                       pend_d[i] = pend_q[i] + QW'(1);
      end
      dout_d[i] = (st_d[i] == S_HIGH);
      busy_d[i] = (st_d[i] != S_IDLE) || (pend_d[i] != '0);
      full_d[i] = (pend_d[i] == PEND_MAX);
      ovf_d[i]  = (ovf_q[i] & ~bus.ovf_clr) | drop;
    end
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        st_q[i]   <= S_IDLE;
        len_q[i]  <= '0;
        gap_q[i]  <= '0;
        pend_q[i] <= '0;
      end
      dout_q <= '0;
      busy_q <= '0;
      full_q <= '0;
      ovf_q  <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        st_q[i]   <= st_d[i];
        len_q[i]  <= len_d[i];
        gap_q[i]  <= gap_d[i];
        pend_q[i] <= pend_d[i];
      end
      dout_q <= dout_d;
      busy_q <= busy_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.busy      = busy_q;
  assign bus.pend_full = full_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_multi_pulse_widen.sv
// Directed bench for multi_pulse_widen (CH=4, WW=4, MIN_GAP=2, QW=3).
// Inputs change on the falling edge, outputs are checked on the falling edge
// following each rising edge; loop index k is the rising edge just taken.
module tb_multi_pulse_widen;
  localparam int CH = 4;
  localparam int WW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  multi_pulse_widen_if #(.CH(CH), .WW(WW)) bus ();

  multi_pulse_widen #(.CH(CH), .WW(WW), .MIN_GAP(2), .QW(3)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.din = '0;
    bus.width = 4'd3;
    bus.ovf_clr = 1'b0;
    tick();
    checks++; if (bus.dout !== 4'b0) begin failures++; $display("FAIL reset_dout got=%b exp=0000", bus.dout); end
    checks++; if (bus.busy !== 4'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0000", bus.busy); end
    checks++; if (bus.pend_full !== 4'b0) begin failures++; $display("FAIL reset_full got=%b exp=0000", bus.pend_full); end
    checks++; if (bus.ovf !== 4'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0000", bus.ovf); end
    rst_n = 1'b1;
  endtask

  // One event on ch0, width=3: high after edges 0..2, gap 3..4, idle at 5
  task automatic test_single();
    logic [CH-1:0] ed, eb;
    bus.width = 4'd3;
    for (int k = 0; k < 8; k++) begin
      bus.din = (k == 0) ? 4'b0001 : 4'b0000;
      tick();
      ed = (k < 3) ? 4'b0001 : 4'b0000;
      eb = (k < 5) ? 4'b0001 : 4'b0000;
      checks++; if (bus.dout !== ed) begin failures++; $display("FAIL single_dout k=%0d got=%b exp=%b", k, bus.dout, ed); end
      checks++; if (bus.busy !== eb) begin failures++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, bus.busy, eb); end
    end
  endtask

  // Channel i gets n[i] events on consecutive edges, width=2 -> period 4
  task automatic test_trains(input string tag, input int n [CH]);
    logic [CH-1:0] ed, eb, di;
    bus.width = 4'd2;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < CH; i++) di[i] = (k < n[i]);
      bus.din = di;
      tick();
      for (int i = 0; i < CH; i++) begin
        ed[i] = ((k % 4) < 2) && ((k / 4) < n[i]);
        eb[i] = (k < 4 * n[i]);
      end
      checks++; if (bus.dout !== ed) begin failures++; $display("FAIL %s_dout k=%0d got=%b exp=%b", tag, k, bus.dout, ed); end
      checks++; if (bus.busy !== eb) begin failures++; $display("FAIL %s_busy k=%0d got=%b exp=%b", tag, k, bus.busy, eb); end
    end
    checks++; if (bus.ovf !== 4'b0) begin failures++; $display("FAIL %s_ovf got=%b exp=0000", tag, bus.ovf); end
    checks++; if (bus.pend_full !== 4'b0) begin failures++; $display("FAIL %s_full got=%b exp=0000", tag, bus.pend_full); end
  endtask

  // ch1 held high for 12 edges, width=4 (period 6). Queue fills to 7 at edge 8;
  // edges 9,10,11 are dropped. The edge-6 replay swaps a queued event for a new
  // one, so 9 events are accepted: pulses start at 0,6,...,48.
  // ovf_clr at edge 10 collides with a drop (set wins); at edge 12 it clears.
  task automatic test_saturate();
    logic ed1;
    logic prev;
    int pulses;
    pulses = 0;
    prev = 1'b0;
    bus.width = 4'd4;
    for (int k = 0; k < 60; k++) begin
      bus.din = (k < 12) ? 4'b0010 : 4'b0000;
      bus.ovf_clr = (k == 10 || k == 12);
      tick();
      ed1 = ((k % 6) < 4) && ((k / 6) < 9);
      checks++; if (bus.dout !== {2'b00, ed1, 1'b0}) begin failures++; $display("FAIL sat_dout k=%0d got=%b exp=%b", k, bus.dout, {2'b00, ed1, 1'b0}); end
      if (bus.dout[1] === 1'b1 && prev === 1'b0) pulses++;
      prev = bus.dout[1];
      if (k == 7) begin checks++; if (bus.pend_full !== 4'b0000) begin failures++; $display("FAIL sat_full_pre got=%b exp=0000", bus.pend_full); end end
      if (k == 8) begin checks++; if (bus.pend_full !== 4'b0010) begin failures++; $display("FAIL sat_full got=%b exp=0010", bus.pend_full); end end
      if (k == 8) begin checks++; if (bus.ovf !== 4'b0000) begin failures++; $display("FAIL sat_ovf_pre got=%b exp=0000", bus.ovf); end end
      if (k == 9) begin checks++; if (bus.ovf !== 4'b0010) begin failures++; $display("FAIL sat_ovf_first_drop got=%b exp=0010", bus.ovf); end end
      if (k == 10) begin checks++; if (bus.ovf !== 4'b0010) begin failures++; $display("FAIL ovf_clr_set_wins got=%b exp=0010", bus.ovf); end end
      if (k == 12) begin checks++; if (bus.ovf !== 4'b0000) begin failures++; $display("FAIL ovf_clr got=%b exp=0000", bus.ovf); end end
      if (k == 12) begin checks++; if (bus.pend_full !== 4'b0000) begin failures++; $display("FAIL sat_full_release got=%b exp=0000", bus.pend_full); end end
    end
    bus.ovf_clr = 1'b0;
    checks++; if (pulses !== 9) begin failures++; $display("FAIL sat_pulse_count got=%0d exp=9", pulses); end
    checks++; if (bus.busy !== 4'b0) begin failures++; $display("FAIL sat_busy_end got=%b exp=0000", bus.busy); end
  endtask

  // width=0 on ch3, two events: 1-cycle pulses at edges 0 and 3, idle at 6
  task automatic test_width0();
    logic [CH-1:0] ed, eb;
    bus.width = 4'd0;
    for (int k = 0; k < 10; k++) begin
      bus.din = (k < 2) ? 4'b1000 : 4'b0000;
      tick();
      ed = (k == 0 || k == 3) ? 4'b1000 : 4'b0000;
      eb = (k < 6) ? 4'b1000 : 4'b0000;
      checks++; if (bus.dout !== ed) begin failures++; $display("FAIL w0_dout k=%0d got=%b exp=%b", k, bus.dout, ed); end
      checks++; if (bus.busy !== eb) begin failures++; $display("FAIL w0_busy k=%0d got=%b exp=%b", k, bus.busy, eb); end
    end
  endtask

  // width 5 -> 2 during the first pulse: high 0..4, gap 5..6, high 7..8, idle 11
  task automatic test_width_change();
    logic [CH-1:0] ed, eb;
    bus.width = 4'd5;
    for (int k = 0; k < 14; k++) begin
      bus.din = (k < 2) ? 4'b0001 : 4'b0000;
      if (k == 2) bus.width = 4'd2;
      tick();
      ed = ((k <= 4) || (k == 7) || (k == 8)) ? 4'b0001 : 4'b0000;
      eb = (k < 11) ? 4'b0001 : 4'b0000;
      checks++; if (bus.dout !== ed) begin failures++; $display("FAIL wchg_dout k=%0d got=%b exp=%b", k, bus.dout, ed); end
      checks++; if (bus.busy !== eb) begin failures++; $display("FAIL wchg_busy k=%0d got=%b exp=%b", k, bus.busy, eb); end
    end
  endtask

  // ch0 and ch2 with pend=3, then reset; afterwards a fresh single event
  task automatic test_reset_mid();
    bus.width = 4'd4;
    for (int k = 0; k < 4; k++) begin
      bus.din = 4'b0101;
      tick();
    end
    checks++; if (bus.busy !== 4'b0101) begin failures++; $display("FAIL rmid_busy_pre got=%b exp=0101", bus.busy); end
    bus.din = 4'b0000;
    rst_n = 1'b0;
    tick();
    checks++; if (bus.dout !== 4'b0) begin failures++; $display("FAIL rmid_dout got=%b exp=0000", bus.dout); end
    checks++; if (bus.busy !== 4'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0000", bus.busy); end
    checks++; if (bus.pend_full !== 4'b0) begin failures++; $display("FAIL rmid_full got=%b exp=0000", bus.pend_full); end
    checks++; if (bus.ovf !== 4'b0) begin failures++; $display("FAIL rmid_ovf got=%b exp=0000", bus.ovf); end
    rst_n = 1'b1;
    test_single();
  endtask

  initial begin
    bus.din = '0;
    bus.width = '0;
    bus.ovf_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_trains("three", '{3, 0, 0, 0});
    test_saturate();
    test_width0();
    test_width_change();
    test_reset_mid();
    test_trains("allch", '{1, 2, 3, 4});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
